// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and helpers for the multi-cycle execute ALU.
package alu_pkg;

   localparam int unsigned OPW = 4;

   localparam logic [OPW-1:0] OP_AND  = 4'd0;
   localparam logic [OPW-1:0] OP_OR   = 4'd1;
   localparam logic [OPW-1:0] OP_ADD  = 4'd2;
   localparam logic [OPW-1:0] OP_SUB  = 4'd3;
   localparam logic [OPW-1:0] OP_SLT  = 4'd4;
   localparam logic [OPW-1:0] OP_XOR  = 4'd5;
   localparam logic [OPW-1:0] OP_ADDI = 4'd6;
   localparam logic [OPW-1:0] OP_SLTU = 4'd7;
   localparam logic [OPW-1:0] OP_SLL  = 4'd8;
   localparam logic [OPW-1:0] OP_SRL  = 4'd9;
   localparam logic [OPW-1:0] OP_SRA  = 4'd10;
   localparam logic [OPW-1:0] OP_MUL  = 4'd11;
   localparam logic [OPW-1:0] OP_DIV  = 4'd12;
   localparam logic [OPW-1:0] OP_DIVU = 4'd13;
   localparam logic [OPW-1:0] OP_REM  = 4'd14;
   localparam logic [OPW-1:0] OP_REMU = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic is_multicycle(input logic [OPW-1:0] op);
      return op >= OP_MUL;
   endfunction

   // REM/REMU select the remainder rather than the quotient
   function automatic logic is_rem(input logic [OPW-1:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_seq_div.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// The first bit is produced on the start edge so the result is final XLEN-1 edges later.
module alu_seq_div #(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] quotient_o,
   output logic [XLEN-1:0] remainder_o,
   output logic            done_o
);

   localparam int unsigned SHW = $clog2(XLEN);

   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [SHW-1:0]  cnt_q, cnt_d;
   logic            done_q, done_d;

   logic [XLEN-1:0] src_rem, src_quo, src_dvs, rem_step, quo_step;
   logic [XLEN:0]   shifted, diff;
   logic            ge;

   // One restoring step; on start the operands feed the step directly
   always_comb begin
      src_rem  = start_i ? '0 : rem_q;
      src_quo  = start_i ? dividend_i : quo_q;
      src_dvs  = start_i ? divisor_i : dvs_q;
      shifted  = {src_rem, src_quo[XLEN-1]};
      diff     = shifted - {1'b0, src_dvs};
      ge       = ~diff[XLEN];
      rem_step = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
      quo_step = {src_quo[XLEN-2:0], ge};
   end

   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      done_d = done_q;
      if (start_i) begin
         rem_d  = rem_step;
         quo_d  = quo_step;
         dvs_d  = divisor_i;
         cnt_d  = SHW'(XLEN - 1);
         done_d = 1'b0;
      end else if (cnt_q != '0) begin
         rem_d  = rem_step;
         quo_d  = quo_step;
         cnt_d  = cnt_q - SHW'(1);
         done_d = (cnt_q == SHW'(1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;
   assign done_o      = done_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/shift ops plus iterative
// MUL and DIV/REM, with valid/ready handshakes on both sides.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] in1,
   input  logic [XLEN-1:0] in2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy
);

   localparam int unsigned SHW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_q, state_d;
   logic [SHW-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
   logic            zero_q, zero_d, qneg_q, qneg_d, rneg_q, rneg_d, rsel_q, rsel_d;

   logic [XLEN-1:0] alu_c, a_mag, b_mag, acc_nx, div_quo, div_rem;
   logic [SHW-1:0]  shamt;
   logic            signed_div, a_neg, b_neg, div_start, div_done;

   // Single-cycle datapath and divider operand magnitudes
   always_comb begin
      shamt      = in2[SHW-1:0];
      signed_div = (op == OP_DIV) || (op == OP_REM);
      a_neg      = signed_div & in1[XLEN-1];
      b_neg      = signed_div & in2[XLEN-1];
      a_mag      = a_neg ? -in1 : in1;
      b_mag      = b_neg ? -in2 : in2;
      alu_c      = '0;
      case (op)
         OP_AND:          alu_c = in1 & in2;
         OP_OR:           alu_c = in1 | in2;
         OP_ADD, OP_ADDI: alu_c = in1 + in2;
         OP_SUB:          alu_c = in1 - in2;
         OP_SLT:          alu_c = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
         OP_XOR:          alu_c = in1 ^ in2;
         OP_SLTU:         alu_c = {{(XLEN-1){1'b0}}, in1 < in2};
         OP_SLL:          alu_c = in1 << shamt;
         OP_SRL:          alu_c = in1 >> shamt;
         OP_SRA:          alu_c = $signed(in1) >>> shamt;
         default:         alu_c = '0;
      endcase
   end

   alu_seq_div #(.XLEN(XLEN)) u_div (
      .clk         (clk),
      .rst         (rst),
      .start_i     (div_start),
      .dividend_i  (a_mag),
      .divisor_i   (b_mag),
      .quotient_o  (div_quo),
      .remainder_o (div_rem),
      .done_o      (div_done)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      zero_d    = zero_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      rsel_d    = rsel_q;
      div_start = 1'b0;
      acc_nx    = acc_q + (mplier_q[0] ? mcand_q : '0);

      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  zero_d = (in1 == in2);
                  if (!is_multicycle(op)) begin
                     result_d = alu_c;
                     state_d  = ST_DONE;
                  end else if (op == OP_MUL) begin
                     mcand_d  = in1;
                     mplier_d = in2;
                     acc_d    = '0;
                     cnt_d    = SHW'(XLEN - 1);
                     state_d  = ST_MUL;
                  end else if (in2 == '0) begin
                     result_d = is_rem(op) ? in1 : '1;
                     state_d  = ST_DONE;
                  end else if (signed_div && (in1 == MIN_NEG) && (in2 == '1)) begin
                     result_d = is_rem(op) ? '0 : in1;
                     state_d  = ST_DONE;
                  end else begin
                     qneg_d    = a_neg ^ b_neg;
                     rneg_d    = a_neg;
                     rsel_d    = is_rem(op);
                     div_start = 1'b1;
                     cnt_d     = SHW'(XLEN - 1);
                     state_d   = ST_DIV;
                  end
               end
            end
            ST_MUL: begin
               acc_d    = acc_nx;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               if (cnt_q == '0) begin
                  result_d = acc_nx;
                  state_d  = ST_DONE;
               end else begin
                  cnt_d = cnt_q - SHW'(1);
               end
            end
            ST_DIV: begin
               if (cnt_q == '0) begin
                  if (div_done) begin
                     if (rsel_q) result_d = rneg_q ? -div_rem : div_rem;
                     else        result_d = qneg_q ? -div_quo : div_quo;
                     state_d = ST_DONE;
                  end
               end else begin
                  cnt_d = cnt_q - SHW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         rsel_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         rsel_q   <= rsel_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
   assign result    = result_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at XLEN=64.
module tb_alu_mc;

   localparam int unsigned XLEN = 64;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

   logic            clk = 1'b0;
   logic            rst, in_valid, flush, out_ready;
   logic [3:0]      op;
   logic [XLEN-1:0] in1, in2;
   logic            in_ready, out_valid, zero, busy;
   logic [XLEN-1:0] result;

   int checks = 0;
   int errors = 0;

   alu_mc #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .in1       (in1),
      .in2       (in2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for in_ready, present one op, return just after the accept edge
   task automatic issue(input string tag, input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
      int n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      op       = o;
      in1      = a;
      in2      = b;
      tick();
      in_valid = 1'b0;
   endtask

   // Count edges after accept until out_valid; flag cycles that are not busy/stalled
   task automatic wait_valid(output int lat, output int viol);
      lat  = 0;
      viol = 0;
      while (!out_valid && lat < 200) begin
         if (!busy || in_ready) viol++;
         tick();
         lat++;
      end
   endtask

   task automatic run(input string tag, input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] exp_res, input int exp_lat, input logic exp_zero);
      int lat, viol;
      issue(tag, o, a, b);
      wait_valid(lat, viol);
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_res"}, result, exp_res);
      chk({tag, "_zero"}, 64'(zero), 64'(exp_zero));
      if (exp_lat > 0) chk({tag, "_busy"}, 64'(viol), 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, viol, stray;
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      op = '0; in1 = '0; in2 = '0;
      tick();
      tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_zero", 64'(zero), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      tick();
      chk("rst_ready", 64'(in_ready), 64'd1);

      run("add",   4'd2,  64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 0, 1'b0);
      run("addi",  4'd6,  64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 0, 1'b0);
      run("sub",   4'd3,  64'd9, 64'd9, 64'd0, 0, 1'b1);
      run("and",   4'd0,  64'hF0F0, 64'hFF00, 64'hF000, 0, 1'b0);
      run("or",    4'd1,  64'hF0F0, 64'h0F0F, 64'hFFFF, 0, 1'b0);
      run("xor",   4'd5,  64'hFF00, 64'h0FF0, 64'hF0F0, 0, 1'b0);
      run("slt",   4'd4,  ONES, 64'd1, 64'd1, 0, 1'b0);
      run("sltu",  4'd7,  ONES, 64'd1, 64'd0, 0, 1'b0);
      run("sll",   4'd8,  64'd1, 64'd4, 64'd16, 0, 1'b0);
      run("sra",   4'd10, MINV, 64'd63, ONES, 0, 1'b0);
      run("srl",   4'd9,  MINV, 64'd63, 64'd1, 0, 1'b0);
      run("mul",   4'd11, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
          64'hFFFF_FFFE_0000_0001, 64, 1'b1);
      run("mulneg", 4'd11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 64, 1'b0);
      run("div",   4'd12, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1'b0);
      run("rem",   4'd14, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 64, 1'b0);
      run("divn2", 4'd12, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1'b0);
      run("remn2", 4'd14, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64, 1'b0);
      run("divu",  4'd13, 64'd100, 64'd7, 64'd14, 64, 1'b0);
      run("remu",  4'd15, 64'd100, 64'd7, 64'd2, 64, 1'b0);
      run("divu0", 4'd13, 64'd7, 64'd0, ONES, 0, 1'b0);
      run("remu0", 4'd15, 64'd7, 64'd0, 64'd7, 0, 1'b0);
      run("divovf", 4'd12, MINV, ONES, MINV, 0, 1'b0);
      run("removf", 4'd14, MINV, ONES, 64'd0, 0, 1'b0);

      // Backpressure: result/zero held and no accept while out_ready stays low
      issue("bp", 4'd2, 64'd4, 64'd4);
      wait_valid(lat, viol);
      chk("bp_lat", 64'(lat), 64'd0);
      stray = 0;
      for (int i = 0; i < 5; i++) begin
         if (result !== 64'd8 || zero !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) stray++;
         tick();
      end
      chk("bp_hold", 64'(stray), 64'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_ready", 64'(in_ready), 64'd1);
      chk("bp_drop", 64'(out_valid), 64'd0);

      // Flush ten cycles into a divide
      issue("fl", 4'd12, 64'd100, 64'd7);
      stray = 0;
      for (int i = 0; i < 9; i++) begin
         if (out_valid) stray++;
         tick();
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_ready", 64'(in_ready), 64'd1);
      chk("fl_busy", 64'(busy), 64'd0);
      for (int i = 0; i < 70; i++) begin
         if (out_valid) stray++;
         tick();
      end
      chk("fl_novalid", 64'(stray), 64'd0);
      run("fl_add", 4'd2, 64'd1, 64'd2, 64'd3, 0, 1'b0);

      // Reset in the middle of a multiply
      issue("rm", 4'd11, 64'd6, 64'd6);
      for (int i = 0; i < 20; i++) tick();
      chk("rm_zero_pre", 64'(zero), 64'd1);
      rst = 1'b1;
      tick();
      chk("rm_valid", 64'(out_valid), 64'd0);
      chk("rm_result", result, 64'd0);
      chk("rm_zero", 64'(zero), 64'd0);
      chk("rm_busy", 64'(busy), 64'd0);
      rst = 1'b0;
      tick();
      chk("rm_ready", 64'(in_ready), 64'd1);
      run("rm_add", 4'd2, 64'd10, 64'd20, 64'd30, 0, 1'b0);
      run("rm_mul", 4'd11, 64'd7, 64'd6, 64'd42, 64, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
